dripper_valve_driver: RTL
=========================

// Module: dripper_valve_driver
// PURPOSE
//   Actuator end of the dripper command: turns the combinational valve request into a timed drive signal for the drip solenoid.
//   Enforces min-on/min-off anti-short-cycling and verifies the flow sensor; latches a fault on no-flow or stuck-open.
//   Sits between the dripper logic and the solenoid pin; the irrigation controller supplies inhibit.
// PARAMETERS
//   CLK_DIV        50_000_000  clk cycles per timing tick (1 s at 50 MHz); benches use 4
//   MIN_ON         5           min ticks in OPEN before a request drop may close the valve
//   MIN_OFF        3           min ticks after CLOSING before a new open is allowed
//   OPEN_TIMEOUT   4           ticks allowed in OPENING for flow to appear
//   CLOSE_TIMEOUT  4           ticks allowed in CLOSING for flow to stop
//   CNT_W          8           width of tick timers (all timing params < 2**CNT_W)
// PORTS
//   clk            in   1  system clock
//   rst            in   1  asynchronous, active-high reset
//   valve_request  in   1  dripper open command (level)
//   inhibit        in   1  controller override: critical level / supply sensor fault
//   flow_sense     in   1  async flow switch, 1 = water flowing
//   fault_clear    in   1  one-cycle pulse, acknowledges a latched fault
//   valve_drive    out  1  solenoid drive, 1 = energised
//   valve_open     out  1  1 while in OPEN (flow confirmed)
//   fault          out  1  1 while in FAULT
//   fault_code     out  2  00 none, 01 no-flow, 10 stuck-open; held until cleared
//   state          out  3  FSM state for debug/display
// BEHAVIOUR
//   Reset (async, immediate): state=CLOSED, all outputs 0, prescaler=0, timer=0, off_ok=1 (first open not delayed).
//   tick: one-cycle pulse when prescaler == CLK_DIV-1; prescaler then wraps to 0; runs in all states.
//   flow_sense passes a 2-flop synchroniser (flow_s); 2-cycle latency; FSM uses flow_s only.
//   timer: cleared on every state change, +1 per tick, saturates at 2**CNT_W-1.
//   "X elapsed" = tick==1 and timer==X-1 in that cycle.
//   CLOSED   drive=0. -> OPENING when valve_request & !inhibit & off_ok.
//            off_ok set when MIN_OFF elapsed since entering CLOSED from CLOSING/FAULT.
//   OPENING  drive=1. -> CLOSING if inhibit (highest priority);
//            else -> OPEN if flow_s;
//            else -> FAULT code 01 when OPEN_TIMEOUT elapsed.
//            flow_s and timeout in same cycle: flow wins.
//   OPEN     drive=1, valve_open=1.
//            -> CLOSING if inhibit (overrides MIN_ON), or !valve_request with MIN_ON reached (timer >= MIN_ON).
//            Request dropped early: stay OPEN until MIN_ON, then close if still low.
//   CLOSING  drive=0; requests ignored. -> CLOSED (off_ok=0) when !flow_s;
//            else -> FAULT code 10 when CLOSE_TIMEOUT elapsed. Flow stop and timeout together: CLOSED wins.
//   FAULT    drive=0, fault=1, fault_code held. -> CLOSED (off_ok=0) on fault_clear; fault_code -> 00 same edge.
//            fault_clear outside FAULT: ignored.
//   Outputs are registered: drive follows the state of the same cycle (no extra latency beyond the state register).
//   Request to drive rising: 1 cycle (CLOSED->OPENING).
//   inhibit always forces drive=0 within 1 cycle, except in CLOSED/FAULT where it is already 0.
//   Unused state encodings -> CLOSED.
// STRUCTURE
//   irrigation_defs.vh (shared, `include): state encodings CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4;
//     fault codes FC_NONE/FC_NO_FLOW/FC_STUCK_OPEN.
//   Sub-module tick_prescaler (CLK_DIV param; clk, rst -> tick); reused by other timed irrigation blocks.
//   Synchroniser, FSM and timer stay in this module.
// TESTING (CLK_DIV=4, MIN_ON=5, MIN_OFF=3, OPEN_TIMEOUT=4, CLOSE_TIMEOUT=4)
//   1. request=1, flow_sense rises 2 ticks later -> drive=1 one cycle after request; valve_open=1 2 cycles after flow.
//   2. request=1 with flow never rising -> FAULT after 4 ticks, fault_code=01, drive=0.
//      fault_clear -> CLOSED, no reopen for 3 ticks.
//   3. Open, drop request after 1 tick in OPEN -> stays OPEN until timer=5, then CLOSING; flow stops -> CLOSED.
//   4. Inhibit pulse during OPEN at timer=1 -> drive=0 next cycle, CLOSING regardless of MIN_ON.
//      Flow held high 4 ticks -> FAULT, fault_code=10.
//   5. Close, then request=1 immediately -> remains CLOSED for 3 ticks, enters OPENING on the 3rd tick cycle.
//   6. Assert rst mid-OPENING (asynchronous to clk) -> drive=0 and state=CLOSED before next edge.
//      After release, request reopens at once (off_ok=1).

Source files
------------

// File: rtl/dripper_valve_driver_pkg.sv
// Shared definitions for the drip valve driver: FSM state encodings, fault codes,
// and the state-to-output decode used to build the registered outputs.
package dripper_valve_driver_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } valve_state_e;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_NO_FLOW    = 2'b01,
    FC_STUCK_OPEN = 2'b10
  } fault_code_e;

  typedef struct packed {
    logic drive;
    logic open;
    logic fault;
  } valve_out_t;

  // Solenoid is energised only while opening or open.
  function automatic valve_out_t decode_outputs(input valve_state_e s);
    valve_out_t o;
    o.drive = (s == ST_OPENING) || (s == ST_OPEN);
    o.open  = (s == ST_OPEN);
    o.fault = (s == ST_FAULT);
    return o;
  endfunction

endpackage

// File: rtl/dripper_valve_driver_tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle timing tick.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (counter -> 0)
//   tick out 1 for one cycle when the counter reaches CLK_DIV-1
module tick_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] cnt;

  assign tick = (cnt == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dripper_valve_driver.sv
// dripper_valve_driver: turns the dripper's level valve request into a timed
// solenoid drive with min-on/min-off protection and flow-sensor supervision.
//   clk, rst       clock, asynchronous active-high reset
//   valve_request  dripper open command (level)
//   inhibit        controller override, forces the valve closed
//   flow_sense     asynchronous flow switch (1 = flowing)
//   fault_clear    one-cycle fault acknowledge
//   valve_drive    solenoid drive
//   valve_open     high in OPEN (flow confirmed)
//   fault          high in FAULT
//   fault_code     latched cause: none / no-flow / stuck-open
//   state          FSM state for debug
module dripper_valve_driver
  import dripper_valve_driver_pkg::*;
#(
  parameter int CLK_DIV       = 50_000_000,
  parameter int MIN_ON        = 5,
  parameter int MIN_OFF       = 3,
  parameter int OPEN_TIMEOUT  = 4,
  parameter int CLOSE_TIMEOUT = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valve_request,
  input  logic       inhibit,
  input  logic       flow_sense,
  input  logic       fault_clear,
  output logic       valve_drive,
  output logic       valve_open,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  logic             tick;
  logic [1:0]       flow_sync;
  logic             flow_s;
  logic [CNT_W-1:0] timer;
  logic             off_ok, off_ok_nx;
  valve_state_e     state_q, state_nx;
  fault_code_e      code_q, code_nx;
  valve_out_t       out_nx;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign flow_s = flow_sync[1];

  // "X ticks elapsed" = the tick that completes the X-th whole tick in a state.
  logic min_off_done, open_to, close_to, min_on_reached;
  assign min_off_done   = tick && (timer == CNT_W'(MIN_OFF - 1));
  assign open_to        = tick && (timer == CNT_W'(OPEN_TIMEOUT - 1));
  assign close_to       = tick && (timer == CNT_W'(CLOSE_TIMEOUT - 1));
  assign min_on_reached = (timer >= CNT_W'(MIN_ON));

  // State register plus the timer, off_ok, fault code and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLOSED;
      code_q      <= FC_NONE;
      off_ok      <= 1'b1;
      timer       <= '0;
      flow_sync   <= '0;
      valve_drive <= 1'b0;
      valve_open  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q   <= state_nx;
      code_q    <= code_nx;
      off_ok    <= off_ok_nx;
      flow_sync <= {flow_sync[0], flow_sense};
      if (state_nx != state_q)  timer <= '0;
      else if (tick && !(&timer)) timer <= timer + 1'b1;
      valve_drive <= out_nx.drive;
      valve_open  <= out_nx.open;
      fault       <= out_nx.fault;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx  = state_q;
    code_nx   = code_q;
    off_ok_nx = off_ok;
    case (state_q)
      ST_CLOSED: begin
        // The open may happen on the same edge that MIN_OFF completes.
        if (min_off_done) off_ok_nx = 1'b1;
        if (valve_request && !inhibit && off_ok_nx) state_nx = ST_OPENING;
      end
      ST_OPENING: begin
        if (inhibit)      state_nx = ST_CLOSING;
        else if (flow_s)  state_nx = ST_OPEN;
        else if (open_to) begin
          state_nx = ST_FAULT;
          code_nx  = FC_NO_FLOW;
        end
      end
      ST_OPEN: begin
        if (inhibit || (!valve_request && min_on_reached)) state_nx = ST_CLOSING;
      end
      ST_CLOSING: begin
        if (!flow_s) begin
          state_nx  = ST_CLOSED;
          off_ok_nx = 1'b0;
        end else if (close_to) begin
          state_nx = ST_FAULT;
          code_nx  = FC_STUCK_OPEN;
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_nx  = ST_CLOSED;
          off_ok_nx = 1'b0;
          code_nx   = FC_NONE;
        end
      end
      default: state_nx = ST_CLOSED;
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    out_nx = decode_outputs(state_nx);
  end

  assign fault_code = code_q;
  assign state      = state_q;

endmodule
